// File: rtl/huc6260_pkg.sv
// -----------------------------------------------------------------------------
// huc6260_pkg
// Shared definitions for the HuC6260 Video Color Encoder:
//   - CPU register address constants
//   - dot-clock mode enumeration (control bits 1:0)
//   - packed GRB palette entry layout
// -----------------------------------------------------------------------------
package huc6260_pkg;

  localparam int PAL_DEPTH = 512;
  localparam int PAL_AW    = 9;

  // CPU register map (A[2:0]); 1, 6 and 7 are unused.
  localparam logic [2:0] VCE_CTRL    = 3'd0;
  localparam logic [2:0] VCE_ADDR_LO = 3'd2;
  localparam logic [2:0] VCE_ADDR_HI = 3'd3;
  localparam logic [2:0] VCE_DATA_LO = 3'd4;
  localparam logic [2:0] VCE_DATA_HI = 3'd5;

  // Dot-clock select; modes 2 and 3 share the fastest divider.
  typedef enum logic [1:0] {
    DOT_MODE_LO     = 2'd0,
    DOT_MODE_MID    = 2'd1,
    DOT_MODE_HI     = 2'd2,
    DOT_MODE_HI_ALT = 2'd3
  } dot_mode_e;

  // Palette entry: [8:6] green, [5:3] red, [2:0] blue.
  typedef struct packed {
    logic [2:0] g;
    logic [2:0] r;
    logic [2:0] b;
  } pal_entry_t;

endpackage

// File: rtl/huc6260_palette_ram.sv
// -----------------------------------------------------------------------------
// huc6260_palette_ram
// 512 x 9 palette memory with one CPU port (synchronous write, asynchronous
// read) and one asynchronous video read port. The consumer registers the
// video read, so a CPU write reaches the pixel output one clock later.
//
// Optional build macro: VCE_PALETTE_INIT_EN
//   defined   - reset loads entry i with i (identity GRB ramp)
//   undefined - contents are left for software to load
//
// Ports:
//   clock, reset_N   master clock, synchronous active-low reset
//   cpu_we           write strobe for cpu_addr
//   cpu_addr         CPU port address
//   cpu_wdata        entry to write
//   cpu_rdata        entry currently at cpu_addr
//   vid_addr         video port address
//   vid_rdata        entry currently at vid_addr
// -----------------------------------------------------------------------------
module huc6260_palette_ram
  import huc6260_pkg::*;
(
  input  logic              clock,
  input  logic              reset_N,
  input  logic              cpu_we,
  input  logic [PAL_AW-1:0] cpu_addr,
  input  pal_entry_t        cpu_wdata,
  output pal_entry_t        cpu_rdata,
  input  logic [PAL_AW-1:0] vid_addr,
  output pal_entry_t        vid_rdata
);

  pal_entry_t mem [PAL_DEPTH];

`ifdef VCE_PALETTE_INIT_EN
  always_ff @(posedge clock) begin
    if (!reset_N) begin
      for (int i = 0; i < PAL_DEPTH; i++) begin
        mem[i] <= pal_entry_t'(9'(i));
      end
    end else if (cpu_we) begin
      mem[cpu_addr] <= cpu_wdata;
    end
  end
`else
  logic unused_reset;
  assign unused_reset = reset_N;

  // NOTE: the array is deliberately left out of reset so it maps onto RAM
  // primitives; software loads every entry it uses.
  always_ff @(posedge clock) begin
    if (cpu_we) begin
      mem[cpu_addr] <= cpu_wdata;
    end
  end
`endif

  assign cpu_rdata = mem[cpu_addr];
  assign vid_rdata = mem[vid_addr];

endmodule

// File: rtl/huc6260_vce.sv
// -----------------------------------------------------------------------------
// huc6260_vce
// HuC6260 Video Color Encoder: maps the HuC6270 9-bit pixel index stream to
// 3-bit RGB through a 512-entry palette, paces the VDC with a dot-clock
// enable, and exposes a byte-wide CPU register port.
//
// Optional build macro: VCE_PALETTE_INIT_EN (see huc6260_palette_ram).
//
// Ports:
//   clock, reset_N        master clock, synchronous active-low reset
//   VD[8:0]               pixel index (8 sprite, 7:4 palette, 3:0 color)
//   HSYN, VSYN            active-low syncs; either low blanks RGB
//   A[2:0]                CPU register address
//   D[8:0]                CPU data (7:0 used, 8 driven 0 on reads)
//   CS_n, RD_n, WR_n      active-low CPU strobes
//   VIDEO_R/G/B[2:0]      registered colour outputs
//   CK                    one-clock dot-clock enable pulse
//   address_mode[1:0]     current dot-clock select
// -----------------------------------------------------------------------------
module huc6260_vce
  import huc6260_pkg::*;
#(
  parameter int CLK_DIV_LO  = 4,
  parameter int CLK_DIV_MID = 3,
  parameter int CLK_DIV_HI  = 2
) (
  input  logic       clock,
  input  logic       reset_N,
  input  logic [8:0] VD,
  input  logic       HSYN,
  input  logic       VSYN,
  input  logic [2:0] A,
  inout  wire  [8:0] D,
  input  logic       CS_n,
  input  logic       RD_n,
  input  logic       WR_n,
  output logic [2:0] VIDEO_R,
  output logic [2:0] VIDEO_G,
  output logic [2:0] VIDEO_B,
  output logic       CK,
  output logic [1:0] address_mode
);

  // ---------------------------------------------------------------------------
  // CPU register port
  // ---------------------------------------------------------------------------
  dot_mode_e         dot_mode;
  logic              frame_mode;
  logic              colorburst_strip;
  logic [PAL_AW-1:0] pal_addr;
  logic [7:0]        data_latch;
  logic              wr_q;
  logic              rd_n_q;
  logic              rd_hi_pending;

  logic       wr_cond;
  logic       wr_commit;
  logic       rd_active;
  logic       rd_rise;
  logic       pal_we;
  pal_entry_t pal_wdata;
  pal_entry_t cpu_rdata;
  logic [7:0] rd_data;

  assign wr_cond   = !CS_n && !WR_n;
  // Commit only on the first cycle of a write strobe so a long strobe cannot
  // increment the address more than once.
  assign wr_commit = wr_cond && !wr_q;
  // A simultaneous write strobe takes priority over a read.
  assign rd_active = !CS_n && !RD_n && WR_n;
  assign rd_rise   = RD_n && !rd_n_q;
  assign pal_we    = wr_commit && (A == VCE_DATA_HI);
  assign pal_wdata = pal_entry_t'({D[0], data_latch});

  // Frame mode and colorburst strip have no effect inside this block.
  logic unused_bits;
  assign unused_bits = ^{D[8], frame_mode, colorburst_strip};

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees the pre-edge value of every other register.
  always_ff @(posedge clock) begin
    if (!reset_N) begin
      dot_mode         <= DOT_MODE_LO;
      frame_mode       <= 1'b0;
      colorburst_strip <= 1'b0;
      pal_addr         <= '0;
      data_latch       <= '0;
      wr_q             <= 1'b0;
      rd_n_q           <= 1'b1;
      rd_hi_pending    <= 1'b0;
    end else begin
      wr_q   <= wr_cond;
      rd_n_q <= RD_n;

      if (rd_active && (A == VCE_DATA_HI)) begin
        rd_hi_pending <= 1'b1;
      end else if (rd_rise) begin
        rd_hi_pending <= 1'b0;
      end

      if (wr_commit) begin
        unique case (A)
          VCE_CTRL: begin
            dot_mode         <= dot_mode_e'(D[1:0]);
            frame_mode       <= D[2];
            colorburst_strip <= D[7];
          end
          VCE_ADDR_LO: pal_addr[7:0] <= D[7:0];
          VCE_ADDR_HI: pal_addr[8]   <= D[0];
          VCE_DATA_LO: data_latch    <= D[7:0];
          VCE_DATA_HI: pal_addr      <= pal_addr + 9'd1;
          default: ;
        endcase
      end else if (rd_rise && rd_hi_pending) begin
        // Finishing a data-high read steps to the next entry.
        pal_addr <= pal_addr + 9'd1;
      end
    end
  end

  // NOTE: the default assignment first keeps this block free of latches.
  always_comb begin
    rd_data = 8'hFF;
    case (A)
      VCE_DATA_LO: rd_data = cpu_rdata[7:0];
      VCE_DATA_HI: rd_data = {7'b1111111, cpu_rdata[8]};
      default:     rd_data = 8'hFF;
    endcase
  end

  assign D = rd_active ? {1'b0, rd_data} : 9'bz;

  // ---------------------------------------------------------------------------
  // Dot-clock enable
  // ---------------------------------------------------------------------------
  function automatic logic [2:0] div_for(input dot_mode_e m);
    case (m)
      DOT_MODE_LO:  return 3'(CLK_DIV_LO);
      DOT_MODE_MID: return 3'(CLK_DIV_MID);
      default:      return 3'(CLK_DIV_HI);
    endcase
  endfunction

  logic [2:0] div_cnt;
  logic [2:0] div_len;

  // The divider length is only reloaded on a wrap, so a mode change never
  // produces a runt or stretched dot period.
  always_ff @(posedge clock) begin
    if (!reset_N) begin
      div_cnt <= '0;
      div_len <= 3'(CLK_DIV_LO);
      CK      <= 1'b0;
    end else begin
      CK <= (div_cnt == div_len - 3'd1);
      if (div_cnt == div_len - 3'd1) begin
        div_cnt <= '0;
        div_len <= div_for(dot_mode);
      end else begin
        div_cnt <= div_cnt + 3'd1;
      end
    end
  end

  assign address_mode = dot_mode;

  // ---------------------------------------------------------------------------
  // Pixel path
  // ---------------------------------------------------------------------------
  logic [PAL_AW-1:0] vid_addr;
  pal_entry_t        vid_rdata;

  // Colour 0 of every palette shows the shared background entry.
  assign vid_addr = (VD[3:0] == 4'd0) ? 9'd0 : VD;

  always_ff @(posedge clock) begin
    if (!reset_N) begin
      VIDEO_R <= '0;
      VIDEO_G <= '0;
      VIDEO_B <= '0;
    end else if (!HSYN || !VSYN) begin
      VIDEO_R <= '0;
      VIDEO_G <= '0;
      VIDEO_B <= '0;
    end else begin
      VIDEO_R <= vid_rdata.r;
      VIDEO_G <= vid_rdata.g;
      VIDEO_B <= vid_rdata.b;
    end
  end

  huc6260_palette_ram u_palette (
    .clock     (clock),
    .reset_N   (reset_N),
    .cpu_we    (pal_we),
    .cpu_addr  (pal_addr),
    .cpu_wdata (pal_wdata),
    .cpu_rdata (cpu_rdata),
    .vid_addr  (vid_addr),
    .vid_rdata (vid_rdata)
  );

endmodule

// File: tb/tb_huc6260_vce.sv
// -----------------------------------------------------------------------------
// tb_huc6260_vce
// Directed bench for huc6260_vce: reset state, dot-clock periods per mode,
// palette writes with address wrap, pixel lookup and blanking, background
// colour, CPU read-back with auto-increment, and long write strobes.
// The bench drives D with zero whenever it is not reading, so a DUT that
// drives D when it must not shows up as a nonzero value.
// -----------------------------------------------------------------------------
module tb_huc6260_vce;
  import huc6260_pkg::*;

  logic       clock = 1'b0;
  logic       reset_N;
  logic [8:0] VD;
  logic       HSYN;
  logic       VSYN;
  logic [2:0] A;
  wire  [8:0] D;
  logic       CS_n;
  logic       RD_n;
  logic       WR_n;
  logic [2:0] VIDEO_R;
  logic [2:0] VIDEO_G;
  logic [2:0] VIDEO_B;
  logic       CK;
  logic [1:0] address_mode;

  logic [8:0] d_drv;
  logic       d_oe;

  int checks = 0;
  int errors = 0;

  assign D = d_oe ? d_drv : 9'bz;

  always #5 clock = ~clock;

  huc6260_vce dut (
    .clock        (clock),
    .reset_N      (reset_N),
    .VD           (VD),
    .HSYN         (HSYN),
    .VSYN         (VSYN),
    .A            (A),
    .D            (D),
    .CS_n         (CS_n),
    .RD_n         (RD_n),
    .WR_n         (WR_n),
    .VIDEO_R      (VIDEO_R),
    .VIDEO_G      (VIDEO_G),
    .VIDEO_B      (VIDEO_B),
    .CK           (CK),
    .address_mode (address_mode)
  );

  // ---------------------------------------------------------------------------
  // Bus helpers (stimulus only)
  // ---------------------------------------------------------------------------
  task automatic cpu_write(input logic [2:0] addr, input logic [8:0] data, input int len = 1);
    @(negedge clock);
    A = addr; d_drv = data; d_oe = 1'b1; CS_n = 1'b0; WR_n = 1'b0;
    repeat (len) @(negedge clock);
    CS_n = 1'b1; WR_n = 1'b1; d_drv = 9'h000;
    @(negedge clock);
  endtask

  task automatic cpu_read(input logic [2:0] addr, output logic [8:0] data);
    @(negedge clock);
    A = addr; d_oe = 1'b0; CS_n = 1'b0; RD_n = 1'b0;
    @(negedge clock);
    data = D;
    CS_n = 1'b1; RD_n = 1'b1; d_oe = 1'b1; d_drv = 9'h000;
    @(negedge clock);
  endtask

  task automatic set_addr(input logic [8:0] a);
    cpu_write(VCE_ADDR_LO, {1'b0, a[7:0]});
    cpu_write(VCE_ADDR_HI, {8'h00, a[8]});
  endtask

  task automatic pal_write(input logic [8:0] a, input logic [8:0] v);
    set_addr(a);
    cpu_write(VCE_DATA_LO, {1'b0, v[7:0]});
    cpu_write(VCE_DATA_HI, {8'h00, v[8]});
  endtask

  // Waits for a CK pulse, then counts clocks to the next one (bounded).
  task automatic measure_ck(output int period, output bit ok);
    ok = 1'b0;
    period = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (CK) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      ok = 1'b0;
      for (int i = 1; i <= 20; i++) begin
        @(negedge clock);
        if (CK) begin
          period = i;
          ok = 1'b1;
          break;
        end
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset_N = 1'b0;
    repeat (4) @(negedge clock);
    checks++;
    if ({VIDEO_R, VIDEO_G, VIDEO_B} !== 9'h000) begin
      errors++;
      $display("FAIL reset_rgb: got %h, expected %h", {VIDEO_R, VIDEO_G, VIDEO_B}, 9'h000);
    end
    checks++;
    if (CK !== 1'b0) begin
      errors++;
      $display("FAIL reset_ck: got %b, expected 0", CK);
    end
    checks++;
    if (address_mode !== 2'd0) begin
      errors++;
      $display("FAIL reset_mode: got %0d, expected 0", address_mode);
    end
    reset_N = 1'b1;
    // Chip selected but no strobe: D must stay released.
    CS_n = 1'b0;
    @(negedge clock);
    checks++;
    if (D !== 9'h000) begin
      errors++;
      $display("FAIL idle_d_released: got %h, expected %h", D, 9'h000);
    end
    CS_n = 1'b1;
  endtask

  task automatic test_dot_clock();
    int period;
    bit ok;
    measure_ck(period, ok);
    checks++;
    if (!ok || period != 4) begin
      errors++;
      $display("FAIL ck_period_mode0: got %0d (seen=%0b), expected 4", period, ok);
    end

    cpu_write(VCE_CTRL, 9'h002);
    checks++;
    if (address_mode !== 2'd2) begin
      errors++;
      $display("FAIL mode_after_ctrl02: got %0d, expected 2", address_mode);
    end
    measure_ck(period, ok);
    measure_ck(period, ok);
    checks++;
    if (!ok || period != 2) begin
      errors++;
      $display("FAIL ck_period_mode2: got %0d (seen=%0b), expected 2", period, ok);
    end

    cpu_write(VCE_CTRL, 9'h001);
    checks++;
    if (address_mode !== 2'd1) begin
      errors++;
      $display("FAIL mode_after_ctrl01: got %0d, expected 1", address_mode);
    end
    measure_ck(period, ok);
    measure_ck(period, ok);
    checks++;
    if (!ok || period != 3) begin
      errors++;
      $display("FAIL ck_period_mode1: got %0d (seen=%0b), expected 3", period, ok);
    end

    // Frame-mode and strip bits set, dot mode back to 0.
    cpu_write(VCE_CTRL, 9'h084);
    checks++;
    if (address_mode !== 2'd0) begin
      errors++;
      $display("FAIL mode_after_ctrl84: got %0d, expected 0", address_mode);
    end
    measure_ck(period, ok);
    measure_ck(period, ok);
    checks++;
    if (!ok || period != 4) begin
      errors++;
      $display("FAIL ck_period_mode0_again: got %0d (seen=%0b), expected 4", period, ok);
    end
  endtask

  task automatic test_palette_wrap();
    logic [8:0] rd;
    set_addr(9'h1FF);
    cpu_write(VCE_DATA_LO, 9'h0A5);
    cpu_write(VCE_DATA_HI, 9'h001);   // palette[511] = 1A5, addr -> 0
    cpu_write(VCE_DATA_LO, 9'h007);
    cpu_write(VCE_DATA_HI, 9'h000);   // palette[0] = 007, addr -> 1

    set_addr(9'h1FF);
    cpu_read(VCE_DATA_LO, rd);
    checks++;
    if (rd !== 9'h0A5) begin
      errors++;
      $display("FAIL pal511_lo: got %h, expected %h", rd, 9'h0A5);
    end
    cpu_read(VCE_DATA_HI, rd);        // addr wraps 511 -> 0 on RD_n rise
    checks++;
    if (rd !== 9'h0FF) begin
      errors++;
      $display("FAIL pal511_hi: got %h, expected %h", rd, 9'h0FF);
    end
    cpu_read(VCE_DATA_LO, rd);
    checks++;
    if (rd !== 9'h007) begin
      errors++;
      $display("FAIL pal0_lo_after_wrap: got %h, expected %h", rd, 9'h007);
    end
    cpu_read(VCE_DATA_HI, rd);
    checks++;
    if (rd !== 9'h0FE) begin
      errors++;
      $display("FAIL pal0_hi: got %h, expected %h", rd, 9'h0FE);
    end

    // Background colour 007 on screen: G=0 R=0 B=7.
    VD = 9'h120; HSYN = 1'b1; VSYN = 1'b1;
    @(negedge clock);
    @(negedge clock);
    checks++;
    if ({VIDEO_R, VIDEO_G, VIDEO_B} !== {3'd0, 3'd0, 3'd7}) begin
      errors++;
      $display("FAIL video_pal0_007: got rgb=%0d,%0d,%0d, expected 0,0,7", VIDEO_R, VIDEO_G, VIDEO_B);
    end
  endtask

  task automatic test_pixel();
    pal_write(9'h013, 9'b101_110_011);
    VD = 9'h013; HSYN = 1'b1; VSYN = 1'b1;
    @(negedge clock);
    checks++;
    if ({VIDEO_R, VIDEO_G, VIDEO_B} !== {3'd6, 3'd5, 3'd3}) begin
      errors++;
      $display("FAIL pixel_013: got rgb=%0d,%0d,%0d, expected 6,5,3", VIDEO_R, VIDEO_G, VIDEO_B);
    end
    HSYN = 1'b0;
    @(negedge clock);
    checks++;
    if ({VIDEO_R, VIDEO_G, VIDEO_B} !== 9'h000) begin
      errors++;
      $display("FAIL hsync_blank: got rgb=%0d,%0d,%0d, expected 0,0,0", VIDEO_R, VIDEO_G, VIDEO_B);
    end
    HSYN = 1'b1; VSYN = 1'b0;
    @(negedge clock);
    checks++;
    if ({VIDEO_R, VIDEO_G, VIDEO_B} !== 9'h000) begin
      errors++;
      $display("FAIL vsync_blank: got rgb=%0d,%0d,%0d, expected 0,0,0", VIDEO_R, VIDEO_G, VIDEO_B);
    end
    VSYN = 1'b1;
    @(negedge clock);
    checks++;
    if ({VIDEO_R, VIDEO_G, VIDEO_B} !== {3'd6, 3'd5, 3'd3}) begin
      errors++;
      $display("FAIL pixel_013_unblank: got rgb=%0d,%0d,%0d, expected 6,5,3", VIDEO_R, VIDEO_G, VIDEO_B);
    end

    // Rewrite the entry on screen: 0C8 -> G=3 R=1 B=0.
    pal_write(9'h013, 9'h0C8);
    checks++;
    if ({VIDEO_R, VIDEO_G, VIDEO_B} !== {3'd1, 3'd3, 3'd0}) begin
      errors++;
      $display("FAIL pixel_013_rewrite: got rgb=%0d,%0d,%0d, expected 1,3,0", VIDEO_R, VIDEO_G, VIDEO_B);
    end

    pal_write(9'h000, 9'h1FF);
    VD = 9'h120;
    @(negedge clock);
    checks++;
    if ({VIDEO_R, VIDEO_G, VIDEO_B} !== {3'd7, 3'd7, 3'd7}) begin
      errors++;
      $display("FAIL background_120: got rgb=%0d,%0d,%0d, expected 7,7,7", VIDEO_R, VIDEO_G, VIDEO_B);
    end
    VD = 9'h1F0;
    @(negedge clock);
    checks++;
    if ({VIDEO_R, VIDEO_G, VIDEO_B} !== {3'd7, 3'd7, 3'd7}) begin
      errors++;
      $display("FAIL background_1F0: got rgb=%0d,%0d,%0d, expected 7,7,7", VIDEO_R, VIDEO_G, VIDEO_B);
    end
    VD = 9'h013;
    @(negedge clock);
    checks++;
    if ({VIDEO_R, VIDEO_G, VIDEO_B} !== {3'd1, 3'd3, 3'd0}) begin
      errors++;
      $display("FAIL pixel_013_after_bg: got rgb=%0d,%0d,%0d, expected 1,3,0", VIDEO_R, VIDEO_G, VIDEO_B);
    end
  endtask

  task automatic test_read_back();
    logic [8:0] rd;
    pal_write(9'h005, 9'h03C);
    pal_write(9'h006, 9'h15A);
    set_addr(9'h005);
    cpu_read(VCE_DATA_LO, rd);
    checks++;
    if (rd !== 9'h03C) begin
      errors++;
      $display("FAIL read5_lo: got %h, expected %h", rd, 9'h03C);
    end
    cpu_read(VCE_DATA_HI, rd);
    checks++;
    if (rd !== 9'h0FE) begin
      errors++;
      $display("FAIL read5_hi: got %h, expected %h", rd, 9'h0FE);
    end
    cpu_read(VCE_DATA_LO, rd);        // addr is now 6
    checks++;
    if (rd !== 9'h05A) begin
      errors++;
      $display("FAIL read6_lo_after_inc: got %h, expected %h", rd, 9'h05A);
    end
    cpu_read(VCE_DATA_HI, rd);
    checks++;
    if (rd !== 9'h0FF) begin
      errors++;
      $display("FAIL read6_hi: got %h, expected %h", rd, 9'h0FF);
    end
    cpu_read(3'd1, rd);
    checks++;
    if (rd !== 9'h0FF) begin
      errors++;
      $display("FAIL read_unused_a1: got %h, expected %h", rd, 9'h0FF);
    end
    cpu_read(3'd7, rd);
    checks++;
    if (rd !== 9'h0FF) begin
      errors++;
      $display("FAIL read_unused_a7: got %h, expected %h", rd, 9'h0FF);
    end

    // Writes to unused addresses change neither address nor palette.
    set_addr(9'h006);
    cpu_write(3'd6, 9'h055);
    cpu_write(3'd1, 9'h033);
    cpu_read(VCE_DATA_LO, rd);
    checks++;
    if (rd !== 9'h05A) begin
      errors++;
      $display("FAIL unused_write_ignored: got %h, expected %h", rd, 9'h05A);
    end
  endtask

  task automatic test_long_strobe();
    logic [8:0] rd;
    set_addr(9'h005);
    cpu_write(VCE_DATA_LO, 9'h011);
    // Ten-clock data-high write with RD_n also low: write must win.
    @(negedge clock);
    A = VCE_DATA_HI; d_drv = 9'h000; d_oe = 1'b1;
    CS_n = 1'b0; WR_n = 1'b0; RD_n = 1'b0;
    repeat (5) @(negedge clock);
    checks++;
    if (D !== 9'h000) begin
      errors++;
      $display("FAIL write_wins_d_released: got %h, expected %h", D, 9'h000);
    end
    repeat (5) @(negedge clock);
    CS_n = 1'b1; WR_n = 1'b1; RD_n = 1'b1;
    @(negedge clock);

    cpu_read(VCE_DATA_LO, rd);        // single increment -> addr 6
    checks++;
    if (rd !== 9'h05A) begin
      errors++;
      $display("FAIL long_strobe_single_inc: got %h, expected %h", rd, 9'h05A);
    end
    set_addr(9'h005);
    cpu_read(VCE_DATA_LO, rd);
    checks++;
    if (rd !== 9'h011) begin
      errors++;
      $display("FAIL long_strobe_data_lo: got %h, expected %h", rd, 9'h011);
    end
    cpu_read(VCE_DATA_HI, rd);
    checks++;
    if (rd !== 9'h0FE) begin
      errors++;
      $display("FAIL long_strobe_data_hi: got %h, expected %h", rd, 9'h0FE);
    end
  endtask

  initial begin
    reset_N = 1'b0;
    VD = 9'h000; HSYN = 1'b1; VSYN = 1'b1;
    A = 3'd1; CS_n = 1'b1; RD_n = 1'b1; WR_n = 1'b1;
    d_drv = 9'h000; d_oe = 1'b1;

    test_reset();
    test_dot_clock();
    test_palette_wrap();
    test_pixel();
    test_read_back();
    test_long_strobe();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
